param_stack: RTL and testbench
==============================

# param_stack

Parametrised LIFO stack; next generation of the team's fixed 8-bit, 16-entry stack. Adds configurable width and depth, separate full/empty/count status, simultaneous push+pop (replace-top), synchronous clear, and distinct overflow/underflow pulses alongside a sticky error flag. Sits between a producer/consumer pair in the datapath and is driven by single-cycle request strobes.

## Interface
- `DATA_WIDTH`, 8: width of each entry.
- `DEPTH`, 16: number of entries; must be ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`: count width (derived, not overridden).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `push`  in  1  write `data_in` onto stack this cycle.
- `pop`  in  1  remove top entry this cycle.
- `clear`  in  1  synchronous empty; highest priority after reset.
- `err_clear`  in  1  synchronous clear of sticky `error`.
- `data_in`  in  DATA_WIDTH  push data.
- `data_out`  out  DATA_WIDTH  registered top-of-stack; 0 when empty.
- `count`  out  CNT_W  entries held, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  one-cycle pulse: push rejected.
- `underflow`  out  1  one-cycle pulse: pop rejected.
- `error`  out  1  sticky OR of overflow/underflow.

## Operation
- Reset (`reset_n` low, async): `count`=0, `data_out`=0, `empty`=1, `full`=0, `overflow`=`underflow`=`error`=0. Memory contents not reset.
- Priority per edge: `clear` > push/pop decode. `clear` empties stack, zeroes `data_out`, leaves `error` unchanged, suppresses pulses.
- Decode when `clear`=0:
  - push only, not full: mem[count] ← data_in; count+1; data_out ← data_in.
  - push only, full: ignored; overflow pulse; error set.
  - pop only, not empty: count−1; data_out ← mem[count−2] if count ≥ 2, else 0.
  - pop only, empty: ignored; underflow pulse; error set.
  - push+pop, not empty (including full): replace top: mem[count−1] ← data_in; count unchanged; data_out ← data_in; no pulse.
  - push+pop, empty: push executes (count=1, data_out ← data_in); pop discarded; underflow pulse; error set.
- `error` sticky until `err_clear` or reset; `err_clear` on the same cycle as a new fault leaves `error`=1 (set wins).
- `full`/`empty` derived combinationally from registered `count`.

## Timing
- All outputs registered (or decoded from registered `count`); change only on rising `clk` or async reset.
- Latency: op sampled at edge N is reflected in `data_out`/`count`/flags immediately after edge N; valid for sampling at edge N+1.
- `overflow`/`underflow` high exactly one cycle per offending request; back-to-back faults give continuous high.
- No handshake back-pressure: caller must honour `full`/`empty`; violations are flagged, never corrupt state.
- Reset asserted mid-operation aborts any op; deassertion is synchronised externally; first op honoured at first edge with `reset_n` high.

## Structure
- `stack_pkg`: `clog2`-style helper for `CNT_W`, op-decode enum (`OP_NONE, OP_PUSH, OP_POP, OP_REPLACE`), parameter legality checks.
- Sub-module `stack_mem`: DEPTH×DATA_WIDTH register file, one sync write port, one async read port (addr = count−2 for pop lookahead). Top level holds pointer/count, `data_out` register, flags.
- No FSM beyond the count register; op decode is a combinational case on {clear, push, pop, empty, full}.

## Test plan
- Reset: hold `reset_n`=0 with push=1 → count=0, empty=1, data_out=0x00, error=0; release → first push of 0xA5 gives data_out=0xA5, count=1.
- Fill/overflow (DEPTH=16): push 0x00..0x0F → full=1, data_out=0x0F; 17th push of 0xFF → overflow one cycle, error=1, count=16, data_out=0x0F.
- Drain/underflow: 16 pops → data_out steps 0x0E…0x00 then 0x00 with empty=1; extra pop → underflow one cycle, count=0.
- Replace: stack holds 0x11,0x22; push+pop with 0x33 → count=2, data_out=0x33; pop → data_out=0x11. Repeat at full: no overflow.
- Empty push+pop with 0x44 → count=1, data_out=0x44, underflow pulse, error=1; err_clear → error=0.
- Clear/async reset mid-stream: 5 entries, clear → count=0, data_out=0, error unchanged; reassert `reset_n` between edges → outputs zero without clock edge.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for param_stack.
//   cnt_width()   : bits needed to hold 0..depth
//   addr_width()  : bits needed to index depth entries
//   depth_legal() : parameter legality check used at elaboration
//   op_e          : decoded stack operation for one clock edge
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return depth >= 2;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_WIDTH register file.
//   clk        : write clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write index
//   wr_data_i  : write data
//   rd_addr_i  : asynchronous read index
//   rd_data_o  : asynchronous read data
// Contents are deliberately not reset.
module stack_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered top-of-stack output.
//   clk, reset_n        : clock, async active-low reset
//   push, pop           : single-cycle request strobes (both = replace top)
//   clear               : synchronous empty, overrides push/pop
//   err_clear           : synchronous clear of sticky error
//   data_in             : push data
//   data_out            : registered top-of-stack, 0 when empty
//   count, full, empty  : occupancy status
//   overflow, underflow : one-cycle pulses for rejected push / pop
//   error               : sticky OR of overflow/underflow
module param_stack
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam int AW = addr_width(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("param_stack: DEPTH must be at least 2");
  end

  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  error_q, error_d;

  op_e                   op;
  logic                  full_w, empty_w;
  logic                  mem_we;
  logic [AW-1:0]         mem_wr_addr;
  logic [AW-1:0]         mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Lookahead read of the entry that becomes top after a pop.
  assign mem_rd_addr = AW'(count_q - CNT_W'(2));

  stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (mem_wr_addr),
    .wr_data_i (data_in),
    .rd_addr_i (mem_rd_addr),
    .rd_data_o (mem_rd_data)
  );

  // Request decode; clear wins and suppresses all pulses.
  always_comb begin
    op          = OP_NONE;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (!clear) begin
      case ({push, pop})
        2'b10: begin
          if (full_w) overflow_d = 1'b1;
          else        op = OP_PUSH;
        end
        2'b01: begin
          if (empty_w) underflow_d = 1'b1;
          else         op = OP_POP;
        end
        2'b11: begin
          // On an empty stack the push half still executes.
          if (empty_w) begin
            op          = OP_PUSH;
            underflow_d = 1'b1;
          end else begin
            op = OP_REPLACE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    mem_we      = 1'b0;
    mem_wr_addr = AW'(count_q);
    if (clear) begin
      count_d    = '0;
      data_out_d = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          mem_we     = 1'b1;
          count_d    = count_q + CNT_W'(1);
          data_out_d = data_in;
        end
        OP_POP: begin
          count_d    = count_q - CNT_W'(1);
          data_out_d = (count_q >= CNT_W'(2)) ? mem_rd_data : '0;
        end
        OP_REPLACE: begin
          mem_we      = 1'b1;
          mem_wr_addr = AW'(count_q - CNT_W'(1));
          data_out_d  = data_in;
        end
        default: ;
      endcase
    end
    // A new fault on the same edge as err_clear keeps error set.
    error_d = (error_q & ~err_clear) | overflow_d | underflow_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      error_q     <= error_d;
    end
  end

  assign data_out  = data_out_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign error     = error_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push, pop, clear, err_clear;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;
  logic          full, empty, overflow, underflow, error;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [DW-1:0] m_q[$];
  bit            m_ovf, m_unf, m_err;

  param_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .err_clear (err_clear),
    .data_in   (data_in),
    .data_out  (data_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] top;
    top = (m_q.size() == 0) ? '0 : m_q[$];
    chk({tag, ".count"},     32'(count),     32'(m_q.size()));
    chk({tag, ".data_out"},  32'(data_out),  32'(top));
    chk({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".error"},     32'(error),     32'(m_err));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_err = 0;
  endtask

  task automatic model_apply(input bit p, input bit po, input bit c, input bit ec,
                             input logic [DW-1:0] d);
    m_ovf = 0;
    m_unf = 0;
    if (c) begin
      m_q.delete();
    end else if (p && po) begin
      if (m_q.size() == 0) begin
        m_q.push_back(d);
        m_unf = 1;
      end else begin
        m_q[m_q.size() - 1] = d;
      end
    end else if (p) begin
      if (m_q.size() == DEPTH) m_ovf = 1;
      else                     m_q.push_back(d);
    end else if (po) begin
      if (m_q.size() == 0) m_unf = 1;
      else                 void'(m_q.pop_back());
    end
    m_err = (m_err && !ec) || m_ovf || m_unf;
  endtask

  task automatic step(input string tag, input bit p, input bit po, input bit c,
                      input bit ec, input logic [DW-1:0] d);
    push = p; pop = po; clear = c; err_clear = ec; data_in = d;
    @(posedge clk);
    model_apply(p, po, c, ec, d);
    #1;
    push = 0; pop = 0; clear = 0; err_clear = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    reset_n = 0; push = 1; pop = 0; clear = 0; err_clear = 0; data_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk);
    reset_n = 1; push = 0;
    step("first_push", 1, 0, 0, 0, 8'hA5);

    // Fill and overflow
    step("clr0", 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, 8'(i));
    step("overflow", 1, 0, 0, 0, 8'hFF);
    step("ovf_idle", 0, 0, 0, 0, 8'h00);

    // Drain and underflow
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 0, 8'h00);
    step("underflow", 0, 1, 0, 0, 8'h00);
    step("errclr1", 0, 0, 0, 1, 8'h00);

    // Replace
    step("r_push1", 1, 0, 0, 0, 8'h11);
    step("r_push2", 1, 0, 0, 0, 8'h22);
    step("replace", 1, 1, 0, 0, 8'h33);
    step("r_pop", 0, 1, 0, 0, 8'h00);
    step("clr1", 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step("refill", 1, 0, 0, 0, 8'(8'h80 + i));
    step("replace_full", 1, 1, 0, 0, 8'h5A);
    step("pop_after_rf", 0, 1, 0, 0, 8'h00);

    // Empty push+pop, then sticky error vs err_clear
    step("clr2", 0, 0, 1, 0, 8'h00);
    step("empty_pp", 1, 1, 0, 0, 8'h44);
    step("err_sticky", 0, 0, 0, 0, 8'h00);
    step("errclr2", 0, 0, 0, 1, 8'h00);
    step("pop_to_empty", 0, 1, 0, 0, 8'h00);
    step("errclr_vs_fault", 0, 1, 0, 1, 8'h00);

    // Clear mid-stream keeps error
    for (int i = 0; i < 5; i++) step("five", 1, 0, 0, 0, 8'(8'h60 + i));
    step("clear_mid", 0, 0, 1, 0, 8'h00);

    // Async reset between edges
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, 0, 8'(8'hC0 + i));
    step("pre_rst_ovf", 0, 1, 0, 0, 8'h00);
    #2 reset_n = 0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    reset_n = 1;
    step("post_rst", 1, 0, 0, 0, 8'h77);

    // Randomized traffic, biased to reach both full and empty
    for (int n = 0; n < 600; n++) begin
      int r;
      bit p, po, c, ec;
      r  = $urandom_range(0, 99);
      c  = ($urandom_range(0, 39) == 0);
      ec = ($urandom_range(0, 9) == 0);
      if ((n / 100) % 2 == 0) begin
        p  = (r < 60) || (r >= 85);
        po = (r >= 60);
      end else begin
        p  = (r < 25) || (r >= 90);
        po = (r >= 25) && (r < 95);
      end
      step("random", p, po, c, ec, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
